// File: rtl/dmem_store_buffer.sv
// Data-memory stage: word-addressed array fronted by a posted-store FIFO.
// Stores retire only on idle cycles; loads forward from the youngest matching pending store.
module dmem_store_buffer #(
   parameter int DATA_WIDTH        = 64,
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int ADDR_BITS         = 8,
   parameter int SB_DEPTH          = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mem_enable,
   input  logic                          store_enable,
   input  logic [INSTRUCTION_WIDTH-1:0]  dmem_address,
   input  logic [DATA_WIDTH-1:0]         dmem_dataIn,
   output logic [DATA_WIDTH-1:0]         dmem_dataOut,
   output logic                          dmem_stall,
   output logic [$clog2(SB_DEPTH):0]     sb_count,
   output logic                          sb_empty
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int MEM_DEPTH = 1 << ADDR_BITS;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic [ADDR_BITS-1:0]  sb_addr_q  [SB_DEPTH];
   logic [DATA_WIDTH-1:0] sb_data_q  [SB_DEPTH];
   logic [SB_DEPTH-1:0]   sb_valid_q, sb_valid_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;

   logic                  load, store, idle;
   logic                  full, store_acc, drain;
   logic [ADDR_BITS-1:0]  idx;
   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] fwd_data;
   logic                  unused_addr_hi;

   assign idx            = dmem_address[ADDR_BITS-1:0];
   assign unused_addr_hi = ^dmem_address[INSTRUCTION_WIDTH-1:ADDR_BITS];

   assign load  = mem_enable & ~store_enable;
   assign store = mem_enable & store_enable;
   assign idle  = ~mem_enable;

   // Full and empty come from the count because head==tail is ambiguous.
   assign full      = (count_q == CNT_W'(SB_DEPTH));
   assign store_acc = store & ~full;
   assign drain     = idle & (count_q != '0);

   assign dmem_stall   = store & full;
   assign dmem_dataOut = dout_q;
   assign sb_count     = count_q;
   assign sb_empty     = (count_q == '0);

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = mem_q[idx];
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (sb_valid_q[head_q + PTR_W'(i)] && (sb_addr_q[head_q + PTR_W'(i)] == idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = sb_data_q[head_q + PTR_W'(i)];
         end
      end
   end

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      sb_valid_d = sb_valid_q;
      dout_d     = dout_q;
      if (store_acc) begin
         sb_valid_d[tail_q] = 1'b1;
         tail_d             = tail_q + 1'b1;
         count_d            = count_q + 1'b1;
      end
      if (drain) begin
         sb_valid_d[head_q] = 1'b0;
         head_d             = head_q + 1'b1;
         count_d            = count_q - 1'b1;
      end
      if (load) begin
         dout_d = fwd_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         sb_valid_q <= '0;
         dout_q     <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         sb_valid_q <= sb_valid_d;
         dout_q     <= dout_d;
      end
   end

   // Payload and array storage carry no reset; validity is tracked above.
   always_ff @(posedge clk) begin
      if (store_acc) begin
         sb_addr_q[tail_q] <= idx;
         sb_data_q[tail_q] <= dmem_dataIn;
      end
      if (drain) begin
         mem_q[sb_addr_q[head_q]] <= sb_data_q[head_q];
      end
   end

   logic unused_fwd_hit;
   assign unused_fwd_hit = fwd_hit;

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Data-memory stage directly downstream of the pipeline's ID/EXE-MEM boundary.
- Consumes the pipeline's dmem request (mem_enable, store_enable, dmem_address, dmem_dataIn) and returns dmem_dataOut for the stage-3 load mux.
- Contains a word-addressed data array plus a small posted-store buffer. Stores retire into the array only on cycles with no memory access; loads forward from pending stores.

Parameters:
- DATA_WIDTH, 64, data word width.
- INSTRUCTION_WIDTH, 32, width of dmem_address.
- ADDR_BITS, 8, array index width; depth = 2^ADDR_BITS words.
- SB_DEPTH, 4, store-buffer entries (power of 2, >=2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- mem_enable  input  1  memory access this cycle.
- store_enable  input  1  1 = store, 0 = load; qualified by mem_enable.
- dmem_address  input  INSTRUCTION_WIDTH  word address; only bits [ADDR_BITS-1:0] are used.
- dmem_dataIn  input  DATA_WIDTH  store data.
- dmem_dataOut  output  DATA_WIDTH  load data, registered.
- dmem_stall  output  1  store refused this cycle (buffer full).
- sb_count  output  $clog2(SB_DEPTH)+1  occupied entries.
- sb_empty  output  1  sb_count==0.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous active-low. While rst==0: dmem_dataOut=0, sb_count=0, sb_empty=1, dmem_stall=0, head and tail pointers=0, all entry valids cleared. Array contents are not reset.
- Reset mid-operation: pending stores are discarded. Their data never reaches the array.
- Request decode: load = mem_enable & ~store_enable; store = mem_enable & store_enable; idle = ~mem_enable.
- Store accept: store accepted at a clock edge iff sb_count<SB_DEPTH. The entry {addr,data} is written at tail; tail advances modulo SB_DEPTH.
- dmem_stall: combinational, = store & (sb_count==SB_DEPTH). A stalled store is not enqueued; the requester holds it until accepted. dmem_stall is never asserted for loads or idle cycles.
- Drain: on an idle cycle with sb_count>0, the head entry is written into the array at the clock edge; head advances modulo SB_DEPTH. At most one drain per cycle. No drain on load or store cycles.
- Count update: count+1 on accepted store, count-1 on drain. Store and drain are mutually exclusive, so they never coincide.
- Load, latency 1: request in cycle N, data on dmem_dataOut from the edge ending cycle N until the next load's edge. dmem_dataOut holds its value on store and idle cycles.
- Load forwarding: if any valid buffer entry matches the load index, return the data of the youngest matching entry (closest to tail). Otherwise return array[index]. Forwarding is decided in cycle N from state before that edge.
- Duplicate addresses: duplicate store addresses coexist in the buffer. Drain order is FIFO, so the array ends with the youngest value.
- Wrap-around: head and tail wrap independently. Full/empty are distinguished by sb_count, not pointer equality.
- Bit usage: address bits above ADDR_BITS are ignored; aliasing is permitted. No byte or partial-word writes; every store writes DATA_WIDTH bits.

Test Plan:
- Reset, then load addr 0x05 -> dmem_dataOut=0 through reset. Preload array[5]=0xAA via store + idle cycle, then load 5 -> 0x00000000000000AA one cycle later.
- Store 0x10<-0x1111, then immediately load 0x10 (no idle cycle) -> dmem_dataOut=0x1111 via forwarding; sb_count=1 throughout.
- Stores 0x20<-1, 0x20<-2, 0x20<-3 back-to-back, then load 0x20 -> 3. Then 3 idle cycles -> sb_empty=1, and a load of 0x20 returns 3 from the array.
- Five consecutive stores (SB_DEPTH=4), addr 0..4 -> dmem_stall=1 only on the 5th, sb_count=4. One idle cycle -> count 3; the held 5th store is accepted next cycle.
- Fill buffer, drain 2, store 2 more -> pointer wrap. Drain all; loads of each address return the correct data in store order.
- Assert rst low with sb_count=3 mid-sequence -> outputs reset immediately (async). Buffered data is absent: loads of those addresses return prior array values.
